id_ex_flush_pipe: RTL and testbench



---
 rtl/id_ex_flush_pipe.sv | 148 ++++++++++++++
 tb/tb_id_ex_flush_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_flush_pipe.sv
// id_ex_flush_pipe
//
// Purpose: a STAGES-deep chain of control-bundle registers (ID/EX, EX/MEM,
// MEM/WB, ...) fed from the ID-stage decode. An accepted flush (flush without
// predictor hit) inserts FLUSH_CYCLES bubbles into stage 0 over consecutive
// advances. A stall freezes the chain unless a flush is accepted that cycle.
// A saturating counter records accepted flushes for performance monitoring.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   id_ctrl       control bundle decoded in ID
//   id_valid      id_ctrl carries a real instruction
//   stall         hold all stages this cycle
//   flush         branch/jump resolution requests a flush
//   hit           predictor hit; the flush is not needed and is ignored
//   stage_ctrl    registered bundles, stage k at [k*CTRL_W +: CTRL_W], stage 0 = ID/EX
//   stage_valid   valid bit per stage
//   squash_active high while extra bubbles are still being inserted
//   flush_cnt     number of accepted flushes, saturating
module id_ex_flush_pipe #(
  parameter int CTRL_W       = 6,
  parameter int STAGES       = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic                     id_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     hit,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES-1:0]        stage_valid,
  output logic                     squash_active,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int SQ_W = ($clog2(FLUSH_CYCLES + 1) < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [SQ_W-1:0] SQ_RELOAD = SQ_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [SQ_W-1:0]     sq_cnt_reg, sq_cnt_next;
  logic [CNT_W-1:0]    flush_cnt_reg;
  logic [CTRL_W-1:0]   ctrl_reg  [STAGES];
  logic                valid_reg [STAGES];

  logic kill;
  logic advance;
  logic insert_bubble;

  // A flush that the predictor already covered changes nothing at all.
  assign kill          = flush && !hit;
  // An accepted flush must get its bubble in even while stalled.
  assign advance       = !stall || kill;
  assign insert_bubble = kill || (state_reg == SQUASH);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sq_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sq_cnt_reg <= sq_cnt_next;
    end
  end

  // sq_cnt counts the bubbles still to insert after the current one; the
  // kill cycle itself provides the first bubble.
  always_comb begin
    state_next  = state_reg;
    sq_cnt_next = sq_cnt_reg;
    if (advance) begin
      if (kill) begin
        if (FLUSH_CYCLES > 1) begin
          state_next  = SQUASH;
          sq_cnt_next = SQ_RELOAD;
        end else begin
          state_next  = IDLE;
          sq_cnt_next = '0;
        end
      end else if (state_reg == SQUASH) begin
        if (sq_cnt_reg <= SQ_W'(1)) begin
          // This cycle inserts the final bubble.
          state_next  = IDLE;
          sq_cnt_next = '0;
        end else begin
          sq_cnt_next = sq_cnt_reg - SQ_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------- stage chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg[0]  <= '0;
      valid_reg[0] <= 1'b0;
    end else if (advance) begin
      if (insert_bubble) begin
        ctrl_reg[0]  <= '0;
        valid_reg[0] <= 1'b0;
      end else begin
        ctrl_reg[0]  <= id_ctrl;
        valid_reg[0] <= id_valid;
      end
    end
  end

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctrl_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (advance) begin
          ctrl_reg[gi]  <= ctrl_reg[gi-1];
          valid_reg[gi] <= valid_reg[gi-1];
        end
      end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_out
      assign stage_ctrl[gi*CTRL_W +: CTRL_W] = ctrl_reg[gi];
      assign stage_valid[gi]                 = valid_reg[gi];
    end
  endgenerate

  // ------------------------------------------------------- flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_reg <= '0;
    end else if (kill && (flush_cnt_reg != {CNT_W{1'b1}})) begin
      flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign flush_cnt     = flush_cnt_reg;
  assign squash_active = (state_reg == SQUASH);

endmodule

// File: tb/tb_id_ex_flush_pipe.sv
module tb_id_ex_flush_pipe;

  localparam int CW = 6;
  localparam int ST = 3;
  localparam int NI = 2;

  logic clk;
  logic rst;
  logic [CW-1:0] id_ctrl;
  logic id_valid, stall, flush, hit;

  logic [ST*CW-1:0] sc [NI];
  logic [ST-1:0]    sv [NI];
  logic             sa [NI];
  logic [7:0]       fcnt [NI];
  logic [1:0]       fcnt_a;
  logic [2:0]       fcnt_b;

  // Instance 0: single-bubble flushes, 2-bit counter.
  id_ex_flush_pipe #(.CTRL_W(CW), .STAGES(ST), .FLUSH_CYCLES(1), .CNT_W(2)) u_fc1 (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid), .stall(stall),
    .flush(flush), .hit(hit), .stage_ctrl(sc[0]), .stage_valid(sv[0]),
    .squash_active(sa[0]), .flush_cnt(fcnt_a));

  // Instance 1: three-bubble flushes, 3-bit counter.
  id_ex_flush_pipe #(.CTRL_W(CW), .STAGES(ST), .FLUSH_CYCLES(3), .CNT_W(3)) u_fc3 (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid), .stall(stall),
    .flush(flush), .hit(hit), .stage_ctrl(sc[1]), .stage_valid(sv[1]),
    .squash_active(sa[1]), .flush_cnt(fcnt_b));

  assign fcnt[0] = {6'd0, fcnt_a};
  assign fcnt[1] = {5'd0, fcnt_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each instance is a list of stage contents plus the
  // number of bubbles still owed to stage 0.
  int          fc_of  [NI] = '{1, 3};
  int          max_of [NI] = '{3, 7};
  logic [CW-1:0] m_ctrl  [NI][ST];
  logic          m_valid [NI][ST];
  int            m_owed  [NI];
  int            m_cnt   [NI];

  int checks = 0;
  int failures = 0;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < ST; k++) begin
        m_ctrl[i][k]  = '0;
        m_valid[i][k] = 1'b0;
      end
      m_owed[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_edge(input logic [CW-1:0] c, input logic v,
                            input logic s, input logic f, input logic h);
    bit k_ev = f && !h;
    for (int i = 0; i < NI; i++) begin
      if (!s || k_ev) begin
        for (int k = ST - 1; k >= 1; k--) begin
          m_ctrl[i][k]  = m_ctrl[i][k-1];
          m_valid[i][k] = m_valid[i][k-1];
        end
        if (k_ev) begin
          m_ctrl[i][0] = '0; m_valid[i][0] = 1'b0;
          m_owed[i] = fc_of[i] - 1;
        end else if (m_owed[i] > 0) begin
          m_ctrl[i][0] = '0; m_valid[i][0] = 1'b0;
          m_owed[i]--;
        end else begin
          m_ctrl[i][0] = c; m_valid[i][0] = v;
        end
      end
      if (k_ev && m_cnt[i] < max_of[i]) m_cnt[i]++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [ST*CW-1:0] exp_c;
    logic [ST-1:0]    exp_v;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < ST; k++) begin
        exp_c[k*CW +: CW] = m_ctrl[i][k];
        exp_v[k]          = m_valid[i][k];
      end
      checks++;
      assert (sc[i] === exp_c) else begin
        failures++;
        $error("FAIL %s inst%0d stage_ctrl got=%h exp=%h", tag, i, sc[i], exp_c);
      end
      checks++;
      assert (sv[i] === exp_v) else begin
        failures++;
        $error("FAIL %s inst%0d stage_valid got=%b exp=%b", tag, i, sv[i], exp_v);
      end
      checks++;
      assert (sa[i] === (m_owed[i] > 0)) else begin
        failures++;
        $error("FAIL %s inst%0d squash_active got=%b exp=%b", tag, i, sa[i], (m_owed[i] > 0));
      end
      checks++;
      assert (fcnt[i] === 8'(m_cnt[i])) else begin
        failures++;
        $error("FAIL %s inst%0d flush_cnt got=%0d exp=%0d", tag, i, fcnt[i], m_cnt[i]);
      end
    end
  endtask

  // Drive inputs, take one rising edge, update the model, check 1 ns later.
  task automatic step(input string tag, input logic [CW-1:0] c, input logic v,
                      input logic s, input logic f, input logic h);
    id_ctrl = c; id_valid = v; stall = s; flush = f; hit = h;
    @(posedge clk);
    model_edge(c, v, s, f, h);
    #1;
    check_all(tag);
    $display("step %-10s ctrl=%h v=%b stall=%b flush=%b hit=%b | i0 sc=%h sv=%b sa=%b cnt=%0d | i1 sc=%h sv=%b sa=%b cnt=%0d",
             tag, c, v, s, f, h, sc[0], sv[0], sa[0], fcnt[0], sc[1], sv[1], sa[1], fcnt[1]);
  endtask

  initial begin
    rst = 1'b0; id_ctrl = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0; hit = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2 check_all("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check_all("post_rst");

    // Stream five live bundles.
    for (int n = 1; n <= 5; n++) step("stream", CW'(n), 1'b1, 1'b0, 1'b0, 1'b0);

    // Kill while 2A is presented; 2A must never be latched.
    step("kill_2a", 6'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) step("after_k", 6'h06, 1'b1, 1'b0, 1'b0, 1'b0);

    // Kill followed by two stalls, then release.
    step("kill_st", 6'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) step("stall", 6'h08, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step("release", 6'h08, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush covered by hit, stalled hit flush, then stall plus kill.
    step("flush_hit", 6'h09, 1'b1, 1'b0, 1'b1, 1'b1);
    step("st_hit", 6'h0D, 1'b1, 1'b1, 1'b1, 1'b1);
    step("st_kill", 6'h0A, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) step("drain", 6'h0B, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back kills drive both counters into saturation.
    repeat (8) step("kill_sat", 6'h0C, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) step("drain2", 6'h0E, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      step("rand", CW'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 1) == 1));
    end

    // Reset asserted mid-squash must clear outputs before the next edge.
    step("pre_rst", 6'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step("kill_rst", 6'h12, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    #2 check_all("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    step("after_rst", 6'h13, 1'b1, 1'b0, 1'b0, 1'b0);
    step("after_rst", 6'h14, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
